// File: rtl/pipemem_bus.sv
// pipemem_bus: memory-stage data access unit.
// Runs one req/ack transaction per load/store on a 32-bit little-endian
// data bus, stalls the pipeline while it is in flight, formats load data
// for MEM/WB and flags misaligned accesses to the exception logic.
module pipemem_bus (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwmem,
  input  logic        mrmem,
  input  logic [31:0] malu,
  input  logic [31:0] mb,
  input  logic [1:0]  msize,
  input  logic        msigned,
  input  logic        mcancel,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic [31:0] mmo,
  output logic        mstall,
  output logic        madel,
  output logic        mades,
  output logic [31:0] mbadaddr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_data;
  logic [1:0]  r_off;
  logic [1:0]  r_size;
  logic        r_signed;
  logic        r_load;

  logic        w_idle;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_misalign;
  logic        w_acc;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_mmo;

  // Access qualification: size 11 behaves as a word.
  assign w_idle     = (r_state == S_IDLE);
  assign w_is_half  = (msize == 2'b01);
  assign w_is_word  = msize[1];
  assign w_misalign = (w_is_half & malu[0]) | (w_is_word & (|malu[1:0]));
  assign w_acc      = (mwmem | mrmem) & ~mcancel & ~w_misalign;

  // Exceptions are only reported for the instruction sitting in IDLE;
  // a store wins when both mwmem and mrmem are set.
  assign madel    = w_idle & ~mcancel & w_misalign & mrmem & ~mwmem;
  assign mades    = w_idle & ~mcancel & w_misalign & mwmem;
  assign mbadaddr = w_idle ? malu : 32'h0;

  // Stall from the cycle the access is seen until the ack has been taken.
  assign mstall = (w_idle & w_acc) | (r_state == S_BUSY);

  // Byte enables and lane-replicated write data for the bus request.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    w_be    = 4'b1111;
    w_wdata = mb;
    case (msize)
      2'b00: begin
        w_be    = 4'b0001 << malu[1:0];
        w_wdata = {4{mb[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {malu[1], 1'b0};
        w_wdata = {2{mb[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = mb;
      end
    endcase
  end

  // Load formatting from the captured word and the latched offset/size/sign.
  always_comb begin
    w_byte = r_data[7:0];
    w_half = r_off[1] ? r_data[31:16] : r_data[15:0];
    w_mmo  = r_data;
    case (r_off)
      2'b00:   w_byte = r_data[7:0];
      2'b01:   w_byte = r_data[15:8];
      2'b10:   w_byte = r_data[23:16];
      default: w_byte = r_data[31:24];
    endcase
    case (r_size)
      2'b00:   w_mmo = r_signed ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
      2'b01:   w_mmo = r_signed ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      default: w_mmo = r_data;
    endcase
  end

  // Transaction FSM with registered bus outputs and captured load data.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!clrn) begin
      r_state     <= S_IDLE;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_data      <= 32'h0;
      r_off       <= 2'b00;
      r_size      <= 2'b00;
      r_signed    <= 1'b0;
      r_load      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state     <= S_BUSY;
            r_bus_req   <= 1'b1;
            r_bus_we    <= mwmem;
            r_bus_addr  <= {malu[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_off       <= malu[1:0];
            r_size      <= msize;
            r_signed    <= msigned;
            r_load      <= ~mwmem;
          end
        end
        S_BUSY: begin
          // mcancel is not looked at here: a started transfer always completes.
          if (bus_ack) begin
            r_state   <= S_DONE;
            r_bus_req <= 1'b0;
            r_bus_we  <= 1'b0;
            if (r_load) r_data <= bus_rdata;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;
  assign mmo       = w_mmo;

endmodule

// File: tb/tb_pipemem_bus.sv
// Self-checking bench for pipemem_bus: table-driven combinational,
// load and store vectors plus hand-written multi-cycle sequences.
module tb_pipemem_bus;

  logic        clk = 1'b0;
  logic        clrn;
  logic        mwmem, mrmem;
  logic [31:0] malu, mb;
  logic [1:0]  msize;
  logic        msigned, mcancel;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic [31:0] mmo;
  logic        mstall, madel, mades;
  logic [31:0] mbadaddr;

  int n_cmp = 0;
  int n_err = 0;

  pipemem_bus dut (
    .clk       (clk),
    .clrn      (clrn),
    .mwmem     (mwmem),
    .mrmem     (mrmem),
    .malu      (malu),
    .mb        (mb),
    .msize     (msize),
    .msigned   (msigned),
    .mcancel   (mcancel),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_be    (bus_be),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .bus_ack   (bus_ack),
    .mmo       (mmo),
    .mstall    (mstall),
    .madel     (madel),
    .mades     (mades),
    .mbadaddr  (mbadaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] alu;
    logic [1:0]  size;
    logic        cancel;
    logic        e_madel;
    logic        e_mades;
    logic        e_stall;
  } comb_vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_mmo;
  } load_vec_t;

  typedef struct {
    logic [31:0] alu;
    logic [1:0]  size;
    logic [31:0] data;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata;
  } store_vec_t;

  comb_vec_t  cv[11];
  load_vec_t  lv[7];
  store_vec_t sv[4];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    mwmem   = 1'b0;
    mrmem   = 1'b0;
    malu    = 32'h0;
    mb      = 32'h0;
    msize   = 2'b00;
    msigned = 1'b0;
    mcancel = 1'b0;
  endtask

  // One full access: IDLE cycle, lat+1 BUSY cycles (ack in the last), DONE.
  task automatic access(input string nm, input logic we, input logic re,
                        input logic [31:0] alu, input logic [1:0] size,
                        input logic sgn, input logic [31:0] mb_v,
                        input logic [31:0] rdata, input int lat,
                        input logic [31:0] e_addr, input logic [3:0] e_be,
                        input logic [31:0] e_wdata, input logic chk_mmo,
                        input logic [31:0] e_mmo, input logic cancel_busy);
    int stalls;
    @(negedge clk);
    mwmem = we; mrmem = re; malu = alu; msize = size;
    msigned = sgn; mb = mb_v; mcancel = 1'b0;
    #1;
    stalls = int'(mstall);
    check({nm, " idle stall"}, {31'h0, mstall}, 32'h1);
    for (int c = 0; c <= lat; c++) begin
      @(negedge clk);
      if (cancel_busy) mcancel = 1'b1;
      if (c == lat) begin
        bus_ack = 1'b1; bus_rdata = rdata;
      end else begin
        bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
      end
      #1;
      stalls += int'(mstall);
      check($sformatf("%s busy%0d req", nm, c), {31'h0, bus_req}, 32'h1);
      check($sformatf("%s busy%0d we", nm, c), {31'h0, bus_we}, {31'h0, we});
      check($sformatf("%s busy%0d addr", nm, c), bus_addr, e_addr);
      check($sformatf("%s busy%0d be", nm, c), {28'h0, bus_be}, {28'h0, e_be});
      check($sformatf("%s busy%0d wdata", nm, c), bus_wdata, e_wdata);
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    check({nm, " done stall"}, {31'h0, mstall}, 32'h0);
    check({nm, " done req"}, {31'h0, bus_req}, 32'h0);
    check({nm, " stall cycles"}, stalls, lat + 2);
    if (chk_mmo) check({nm, " mmo"}, mmo, e_mmo);
  endtask

  initial begin
    cv[0]  = '{1'b0, 1'b1, 32'h102, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[1]  = '{1'b0, 1'b1, 32'h102, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
    cv[2]  = '{1'b1, 1'b0, 32'h301, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
    cv[3]  = '{1'b0, 1'b1, 32'h302, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1};
    cv[4]  = '{1'b0, 1'b1, 32'h203, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
    cv[5]  = '{1'b1, 1'b1, 32'h101, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0};
    cv[6]  = '{1'b0, 1'b1, 32'h101, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[7]  = '{1'b0, 1'b1, 32'h104, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1};
    cv[8]  = '{1'b0, 1'b1, 32'h105, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
    cv[9]  = '{1'b0, 1'b0, 32'h107, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
    cv[10] = '{1'b0, 1'b1, 32'h100, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};

    lv[0] = '{32'h203, 2'b00, 1'b1, 32'h8012_3456, 32'h200, 4'b1000, 32'hFFFF_FF80};
    lv[1] = '{32'h203, 2'b00, 1'b0, 32'h8012_3456, 32'h200, 4'b1000, 32'h0000_0080};
    lv[2] = '{32'h201, 2'b00, 1'b1, 32'h8012_3456, 32'h200, 4'b0010, 32'h0000_0034};
    lv[3] = '{32'h202, 2'b01, 1'b1, 32'h8012_3456, 32'h200, 4'b1100, 32'hFFFF_8012};
    lv[4] = '{32'h200, 2'b01, 1'b0, 32'h8012_3456, 32'h200, 4'b0011, 32'h0000_3456};
    lv[5] = '{32'h200, 2'b01, 1'b1, 32'h0000_F00D, 32'h200, 4'b0011, 32'hFFFF_F00D};
    lv[6] = '{32'h104, 2'b11, 1'b0, 32'h8012_3456, 32'h104, 4'b1111, 32'h8012_3456};

    sv[0] = '{32'h306, 2'b01, 32'h0000_ABCD, 32'h304, 4'b1100, 32'hABCD_ABCD};
    sv[1] = '{32'h401, 2'b00, 32'h1234_56A5, 32'h400, 4'b0010, 32'hA5A5_A5A5};
    sv[2] = '{32'h500, 2'b10, 32'hCAFE_F00D, 32'h500, 4'b1111, 32'hCAFE_F00D};
    sv[3] = '{32'h300, 2'b01, 32'hFFFF_1234, 32'h300, 4'b0011, 32'h1234_1234};

    // Reset state.
    idle_inputs();
    bus_ack = 1'b0; bus_rdata = 32'h0; clrn = 1'b0;
    repeat (2) @(negedge clk);
    clrn = 1'b1;
    #1;
    check("rst bus_req", {31'h0, bus_req}, 32'h0);
    check("rst bus_we", {31'h0, bus_we}, 32'h0);
    check("rst bus_addr", bus_addr, 32'h0);
    check("rst bus_be", {28'h0, bus_be}, 32'h0);
    check("rst bus_wdata", bus_wdata, 32'h0);
    check("rst mmo", mmo, 32'h0);
    check("rst mstall", {31'h0, mstall}, 32'h0);
    check("rst madel", {31'h0, madel}, 32'h0);
    check("rst mades", {31'h0, mades}, 32'h0);

    // Combinational qualification in IDLE; inputs removed before the edge.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      mwmem = cv[i].we; mrmem = cv[i].re; malu = cv[i].alu;
      msize = cv[i].size; mcancel = cv[i].cancel;
      #1;
      check($sformatf("comb[%0d] madel", i), {31'h0, madel}, {31'h0, cv[i].e_madel});
      check($sformatf("comb[%0d] mades", i), {31'h0, mades}, {31'h0, cv[i].e_mades});
      check($sformatf("comb[%0d] mstall", i), {31'h0, mstall}, {31'h0, cv[i].e_stall});
      check($sformatf("comb[%0d] mbadaddr", i), mbadaddr, cv[i].alu);
      #1;
      idle_inputs();
    end

    // Word load, ack in the third BUSY cycle: 4 stall cycles.
    access("wload", 1'b0, 1'b1, 32'h100, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 2,
           32'h100, 4'b1111, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check("wload done madel", {31'h0, madel}, 32'h0);
    check("wload done mbadaddr", mbadaddr, 32'h0);

    // Load formatting table, immediate ack.
    for (int i = 0; i < 7; i++) begin
      access($sformatf("load[%0d]", i), 1'b0, 1'b1, lv[i].alu, lv[i].size, lv[i].sgn,
             32'h0, lv[i].rdata, 0, lv[i].e_addr, lv[i].e_be, 32'h0, 1'b1,
             lv[i].e_mmo, 1'b0);
    end

    // Store table; the first one holds the bus for extra cycles.
    for (int i = 0; i < 4; i++) begin
      access($sformatf("store[%0d]", i), 1'b1, 1'b0, sv[i].alu, sv[i].size, 1'b0,
             sv[i].data, 32'h0, (i == 0) ? 2 : 0, sv[i].e_addr, sv[i].e_be,
             sv[i].e_wdata, 1'b0, 32'h0, 1'b0);
    end

    // Misaligned word load: exception, no bus request, no stall.
    @(negedge clk);
    idle_inputs();
    mrmem = 1'b1; malu = 32'h102; msize = 2'b10;
    #1;
    check("mis madel", {31'h0, madel}, 32'h1);
    check("mis mbadaddr", mbadaddr, 32'h102);
    check("mis mstall", {31'h0, mstall}, 32'h0);
    @(negedge clk);
    #1;
    check("mis bus_req", {31'h0, bus_req}, 32'h0);
    mcancel = 1'b1;
    #1;
    check("mis cancel madel", {31'h0, madel}, 32'h0);

    // Cancelled valid load: no request, no stall.
    @(negedge clk);
    malu = 32'h100;
    #1;
    check("cancel mstall", {31'h0, mstall}, 32'h0);
    @(negedge clk);
    #1;
    check("cancel bus_req", {31'h0, bus_req}, 32'h0);
    idle_inputs();

    // Back-to-back loads with immediate ack: 3 cycles each.
    access("b2b0", 1'b0, 1'b1, 32'h800, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 0,
           32'h800, 4'b1111, 32'h0, 1'b1, 32'h1122_3344, 1'b0);
    access("b2b1", 1'b0, 1'b1, 32'h806, 2'b01, 1'b1, 32'h0, 32'h9ABC_0000, 0,
           32'h804, 4'b1100, 32'h0, 1'b1, 32'hFFFF_9ABC, 1'b0);

    // mcancel raised during BUSY: transfer still completes.
    access("cbusy", 1'b0, 1'b1, 32'h900, 2'b10, 1'b0, 32'h0, 32'h0BAD_F00D, 1,
           32'h900, 4'b1111, 32'h0, 1'b1, 32'h0BAD_F00D, 1'b1);

    // Reset while BUSY, then a late ack that must be ignored.
    @(negedge clk);
    idle_inputs();
    mrmem = 1'b1; malu = 32'h600; msize = 2'b10;
    @(negedge clk);
    #1;
    check("rbusy req", {31'h0, bus_req}, 32'h1);
    clrn = 1'b0;
    @(negedge clk);
    clrn = 1'b1; mrmem = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
    #1;
    check("rbusy after req", {31'h0, bus_req}, 32'h0);
    check("rbusy after stall", {31'h0, mstall}, 32'h0);
    check("rbusy after mmo", mmo, 32'h0);
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = 32'h0;
    #1;
    check("late ack req", {31'h0, bus_req}, 32'h0);
    check("late ack stall", {31'h0, mstall}, 32'h0);
    check("late ack mmo", mmo, 32'h0);

    // Normal operation resumes after the abandoned transfer.
    access("post", 1'b0, 1'b1, 32'hA01, 2'b00, 1'b0, 32'h0, 32'h0000_C300, 0,
           32'hA00, 4'b0010, 32'h0, 1'b1, 32'h0000_00C3, 1'b0);

    @(negedge clk);
    idle_inputs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipemem_bus.md
# pipemem_bus

Memory-stage data access unit of the pipelined CPU. It takes the load/store held in the EXE/MEM register, runs a req/ack transaction on the external data bus and stalls the pipeline until the transaction completes. It hands load data to the MEM/WB register (`mmo`) and reports misaligned accesses to the interrupt/exception logic.

## Interface

- No parameters. Bus and data width fixed at 32, little-endian.
- `clk` input 1: clock. All state changes on the posedge.
- `clrn` input 1: reset, synchronous, active-low.
- `mwmem` input 1: MEM-stage instruction is a store.
- `mrmem` input 1: MEM-stage instruction is a load.
- `malu` input 32: effective byte address.
- `mb` input 32: store data, right-justified.
- `msize` input 2: access size. 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `msigned` input 1: sign-extend byte/half loads.
- `mcancel` input 1: MEM-stage instruction is flushed (interrupt). Sampled only in IDLE.
- `bus_req` output 1: bus request, registered.
- `bus_we` output 1: write strobe, registered.
- `bus_addr` output 32: word-aligned address (`[1:0]` = 0), registered.
- `bus_be` output 4: byte enables, registered.
- `bus_wdata` output 32: lane-replicated store data, registered.
- `bus_rdata` input 32: read data, valid with `bus_ack`.
- `bus_ack` input 1: one-cycle transfer completion.
- `mmo` output 32: formatted load data to MEM/WB.
- `mstall` output 1: freeze PC, IF/ID, ID/EXE and EXE/MEM; bubble into MEM/WB.
- `madel` output 1: load address error, combinational.
- `mades` output 1: store address error, combinational.
- `mbadaddr` output 32: faulting address (= `malu`).

## Operation

- **Access valid**: `acc = (mwmem | mrmem) & ~mcancel & ~misalign`.
  - If `mwmem` and `mrmem` are both high, the access is a store.
- **Misalign**: half with `malu[0]`=1; word with `malu[1:0]`≠0.
  - Raises `madel` (load) or `mades` (store) only when `mcancel`=0 and the state is IDLE.
  - No bus transaction and no stall.
- **FSM states**: IDLE, BUSY, DONE.
  - **IDLE**: if `acc`, go to BUSY and load the bus registers in the same edge:
    - `bus_req`=1.
    - `bus_we`=`mwmem`.
    - `bus_addr`={`malu[31:2]`,2'b00}.
    - `bus_be`: byte = 0001<<`a[1:0]`; half = 0011<<{`a[1]`,0}; word = 1111.
    - `bus_wdata`: byte = {4{`mb[7:0]`}}; half = {2{`mb[15:0]`}}; word = `mb`.
    - Also latch `a[1:0]`, `msize` and `msigned`.
  - **BUSY**: hold all bus outputs stable until `bus_ack`. On ack:
    - Go to DONE.
    - Clear `bus_req`/`bus_we`.
    - If the access is a load, capture `bus_rdata` into the data register.
    - `mcancel` is ignored in BUSY; a started transaction always completes.
  - **DONE**: go to IDLE unconditionally. The pipeline advances at the end of this cycle.
- **Stall**: `mstall = (state==IDLE & acc) | state==BUSY`. It is 0 in DONE.
- **Load formatting** (combinational, from the captured data register and latched `a[1:0]`, size and signed):
  - byte lane `a[1:0]`, half lane `a[1]`.
  - Zero- or sign-extended to 32 bits.
  - Word passes through.
- **Stores**: do not update the data register.
- **Reset** (`clrn`=0 at a posedge):
  - State IDLE.
  - `bus_req`, `bus_we`, `bus_addr`, `bus_be` and `bus_wdata` = 0.
  - Data register and latched size/offset/signed = 0.
  - `mmo`=0.
  - `mstall`, `madel` and `mades` are 0 when no access is presented.
- **Reset mid-BUSY**: `bus_req` drops on the next edge and the transaction is abandoned. The bus slave must tolerate a dropped request.

## Timing

- Fastest access, with ack in the first BUSY cycle:
  - cycle 0 IDLE, `mstall`=1;
  - cycle 1 BUSY, `bus_req`=1, ack, `mstall`=1;
  - cycle 2 DONE, `mstall`=0, `mmo` valid.
  - That is 2 stall cycles.
- Each extra cycle of ack latency adds 1 stall cycle.
- `mmo` is valid only in the DONE cycle. MEM/WB captures it at the end of that cycle.
- **Back-to-back memory instructions**: the next one is seen in the IDLE cycle after DONE. Minimum 3 cycles per access, no lost instruction.
- `bus_ack` is honoured only in BUSY and ignored otherwise.
- `madel`, `mades` and `mbadaddr` are combinational from the MEM-stage inputs in IDLE. They are 0 in BUSY and DONE.

## Test plan

- **Word load**: `mrmem`=1, `malu`=0x100, `msize`=10, ack after 3 BUSY cycles with `bus_rdata`=0xDEADBEEF.
  - `bus_addr`=0x100, `bus_be`=1111.
  - `mstall` high for 4 cycles, then DONE with `mmo`=0xDEADBEEF.
- **Signed byte load**: `malu`=0x203, `msigned`=1, `bus_rdata`=0x80123456.
  - `bus_be`=1000, `mmo`=0xFFFFFF80.
  - Same with `msigned`=0: `mmo`=0x00000080.
- **Half store**: `mwmem`=1, `malu`=0x306, `mb`=0x0000ABCD.
  - `bus_we`=1, `bus_addr`=0x304, `bus_be`=1100, `bus_wdata`=0xABCDABCD.
  - Outputs stable until ack.
- **Misaligned word load**: `malu`=0x102.
  - `madel`=1, `mbadaddr`=0x102, `mstall`=0, `bus_req` stays 0.
  - Repeat with `mcancel`=1: `madel`=0.
- **Cancel and back-to-back**:
  - `mcancel`=1 with a valid load: no `bus_req`, no stall.
  - Two consecutive loads with immediate ack: 3 cycles each, both `mmo` values correct.
  - `mcancel` asserted during BUSY: transaction still completes.
- **Reset mid-BUSY**: `clrn`=0 for 1 cycle while BUSY.
  - Next cycle: `bus_req`=0, `mstall`=0, `mmo`=0, state IDLE.
  - A late `bus_ack` is ignored.
